// File: rtl/onehot_grant_pkg.sv
// Shared types and the rotating-priority winner function for onehot_grant_sequencer.
package onehot_grant_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int N_REQ_MAX  = 8;
    localparam int IDX_MAX_W  = 3;
    localparam int N_REQ_DFLT = 3;
    localparam int ID_W       = $clog2(N_REQ_DFLT);

    typedef struct packed {
        logic                 found;
        logic [IDX_MAX_W-1:0] idx;
    } pick_t;

    // First valid index strictly after ptr, wrapping modulo n; the pointer itself is checked last.
    function automatic pick_t rr_winner(input logic [N_REQ_MAX-1:0] valid,
                                        input logic [IDX_MAX_W-1:0] ptr,
                                        input int n);
        pick_t res;
        int    cand;
        res.found = 1'b0;
        res.idx   = {IDX_MAX_W{1'b0}};
        for (int k = 1; k <= N_REQ_MAX; k++) begin
            cand = (int'(ptr) + k) % n;
            if (k <= n && !res.found && valid[cand]) begin
                res.found = 1'b1;
                res.idx   = cand[IDX_MAX_W-1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/onehot_grant_sequencer_rr_pick.sv
// Combinational rotate-and-priority-encode shared by the idle and back-to-back arbitration paths.
module rr_pick
    import onehot_grant_pkg::*;
#(
    parameter int N_REQ = 3,
    localparam int GID_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [GID_W-1:0] rr_ptr,
    output logic             found,
    output logic [GID_W-1:0] index
);

    logic [N_REQ_MAX-1:0] valid_ext_s;
    logic [IDX_MAX_W-1:0] ptr_ext_s;
    pick_t                res_s;

    // Widen to the package's fixed vector size and run the shared winner function.
    always_comb begin
        valid_ext_s              = {N_REQ_MAX{1'b0}};
        valid_ext_s[N_REQ-1:0]   = valid;
        ptr_ext_s                = {IDX_MAX_W{1'b0}};
        ptr_ext_s[GID_W-1:0]     = rr_ptr;
        res_s                    = rr_winner(valid_ext_s, ptr_ext_s, N_REQ);
        found                    = res_s.found;
        index                    = res_s.idx[GID_W-1:0];
    end

endmodule

// File: rtl/onehot_grant_sequencer.sv
// Round-robin one-hot grant sequencer with per-grant beat counts.
// Optional hold watchdog enabled by defining ONEHOT_GRANT_SEQ_WATCHDOG_EN.
module onehot_grant_sequencer
    import onehot_grant_pkg::*;
#(
    parameter int N_REQ    = 3,
    parameter int BEAT_W   = 4,
    parameter int HOLD_MAX = 64,
    localparam int GID_W   = $clog2(N_REQ)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*BEAT_W-1:0] req_beats,
    input  logic                    beat_fire,
    output logic [N_REQ-1:0]        grant,
    output logic [GID_W-1:0]        grant_id,
    output logic                    busy,
    output logic                    last_beat,
    output logic                    proto_err,
    output logic                    timeout_pulse
);

    state_t              state_r;
    logic [N_REQ-1:0]    grant_r;
    logic [GID_W-1:0]    grant_id_r;
    logic [BEAT_W-1:0]   beats_left_r;
    logic [GID_W-1:0]    rr_ptr_r;
    logic                proto_err_r;

    logic                pick_found_s;
    logic [GID_W-1:0]    pick_idx_s;
    logic [GID_W-1:0]    pick_ptr_s;
    logic [N_REQ-1:0]    pick_onehot_s;
    logic [BEAT_W-1:0]   pick_beats_s;
    logic                release_s;
    logic                wd_expire_s;

    // On release the pointer already moves to the finishing winner, so arbitrate from it.
    assign pick_ptr_s = (state_r == GRANT) ? grant_id_r : rr_ptr_r;

    rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
        .valid  (req_valid),
        .rr_ptr (pick_ptr_s),
        .found  (pick_found_s),
        .index  (pick_idx_s)
    );

    // Decode the candidate winner into its grant bit and sampled beat count.
    always_comb begin
        pick_onehot_s             = {N_REQ{1'b0}};
        pick_onehot_s[pick_idx_s] = 1'b1;
        pick_beats_s              = req_beats[pick_idx_s*BEAT_W +: BEAT_W];
    end

    assign release_s = (state_r == GRANT) &&
                       ((beat_fire && (beats_left_r == {BEAT_W{1'b0}})) || wd_expire_s);

`ifdef ONEHOT_GRANT_SEQ_WATCHDOG_EN
    localparam int HC_W = ($clog2(HOLD_MAX + 1) > 8) ? $clog2(HOLD_MAX + 1) : 8;

    logic [HC_W-1:0] hold_cnt_r;
    logic            timeout_r;

    assign wd_expire_s = (state_r == GRANT) && !beat_fire &&
                         (hold_cnt_r == HC_W'(HOLD_MAX - 1));

    // Stall counter: cleared by any beat or grant change, counts idle GRANT cycles.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold_cnt_r <= {HC_W{1'b0}};
            timeout_r  <= 1'b0;
        end else begin
            timeout_r <= wd_expire_s;
            if (state_r != GRANT || beat_fire || release_s) begin
                hold_cnt_r <= {HC_W{1'b0}};
            end else begin
                hold_cnt_r <= hold_cnt_r + HC_W'(1);
            end
        end
    end

    assign timeout_pulse = timeout_r;
`else
    assign wd_expire_s   = 1'b0;
    assign timeout_pulse = 1'b0;
`endif

    // Grant FSM; every output register is updated here so grant switches without a bubble.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            grant_r      <= {N_REQ{1'b0}};
            grant_id_r   <= {GID_W{1'b0}};
            beats_left_r <= {BEAT_W{1'b0}};
            rr_ptr_r     <= GID_W'(N_REQ - 1);
            proto_err_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (beat_fire) begin
                        proto_err_r <= 1'b1;
                    end
                    if (pick_found_s) begin
                        state_r      <= GRANT;
                        grant_r      <= pick_onehot_s;
                        grant_id_r   <= pick_idx_s;
                        beats_left_r <= pick_beats_s;
                    end
                end
                GRANT: begin
                    if (release_s) begin
                        rr_ptr_r <= grant_id_r;
                        if (pick_found_s) begin
                            grant_r      <= pick_onehot_s;
                            grant_id_r   <= pick_idx_s;
                            beats_left_r <= pick_beats_s;
                        end else begin
                            state_r      <= IDLE;
                            grant_r      <= {N_REQ{1'b0}};
                            grant_id_r   <= {GID_W{1'b0}};
                            beats_left_r <= {BEAT_W{1'b0}};
                        end
                    end else if (beat_fire) begin
                        beats_left_r <= beats_left_r - BEAT_W'(1);
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    grant_r      <= {N_REQ{1'b0}};
                    grant_id_r   <= {GID_W{1'b0}};
                    beats_left_r <= {BEAT_W{1'b0}};
                end
            endcase
        end
    end

    assign grant     = grant_r;
    assign grant_id  = grant_id_r;
    assign busy      = (state_r == GRANT);
    assign last_beat = (state_r == GRANT) && (beats_left_r == {BEAT_W{1'b0}});
    assign proto_err = proto_err_r;

endmodule

// File: tb/tb_onehot_grant_sequencer.sv
// Self-checking bench: directed scenarios plus random traffic against a transaction-level model.
module tb_onehot_grant_sequencer;

    localparam int N  = 3;
    localparam int BW = 4;
    localparam int HM = 64;
`ifdef ONEHOT_GRANT_SEQ_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic            clock = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N*BW-1:0] req_beats;
    logic            beat_fire;
    logic [N-1:0]    grant;
    logic [1:0]      grant_id;
    logic            busy, last_beat, proto_err, timeout_pulse;

    always #5 clock = ~clock;

    onehot_grant_sequencer #(.N_REQ(N), .BEAT_W(BW), .HOLD_MAX(HM)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_beats(req_beats),
        .beat_fire(beat_fire), .grant(grant), .grant_id(grant_id), .busy(busy),
        .last_beat(last_beat), .proto_err(proto_err), .timeout_pulse(timeout_pulse)
    );

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: owner index (-1 idle), beats still owed, pointer, sticky error, stall count.
    int m_owner, m_owed, m_ptr, m_hold;
    bit m_perr, m_tmo;

    function automatic int next_winner(input logic [N-1:0] v, input int ptr);
        for (int k = 1; k <= N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic int beats_of(input int i);
        logic [N*BW-1:0] b;
        b = req_beats;
        return int'(b[i*BW +: BW]) + 1;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_owed = 0; m_ptr = N - 1; m_hold = 0; m_perr = 1'b0; m_tmo = 1'b0;
    endtask

    task automatic start_or_idle(input int w);
        m_owner = w;
        m_owed  = (w >= 0) ? beats_of(w) : 0;
        m_hold  = 0;
    endtask

    task automatic model_step();
        bit done;
        m_tmo = 1'b0;
        if (m_owner < 0) begin
            if (beat_fire) m_perr = 1'b1;
            start_or_idle(next_winner(req_valid, m_ptr));
        end else begin
            done = 1'b0;
            if (beat_fire) begin
                m_owed--;
                m_hold = 0;
                if (m_owed == 0) done = 1'b1;
            end else begin
                m_hold++;
                if (WD && m_hold == HM) begin
                    done  = 1'b1;
                    m_tmo = 1'b1;
                end
            end
            if (done) begin
                m_ptr = m_owner;
                start_or_idle(next_winner(req_valid, m_ptr));
            end
        end
    endtask

    task automatic check_outputs();
        check_eq("grant", grant, (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
        check_eq("grant_id", grant_id, (m_owner >= 0) ? m_owner : 0);
        check_eq("busy", busy, m_owner >= 0);
        check_eq("last_beat", last_beat, (m_owner >= 0) && (m_owed == 1));
        check_eq("proto_err", proto_err, m_perr);
        check_eq("timeout", timeout_pulse, m_tmo);
        check_eq("onehot", $countones(grant) <= 1, 1);
    endtask

    task automatic cycle();
        model_step();
        @(posedge clock);
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        reset = 1'b1; req_valid = '0; req_beats = '0; beat_fire = 1'b0;
        model_reset();
        @(posedge clock);
        #1;
        check_outputs();
        reset = 1'b0;
    endtask

    initial begin
        logic [N-1:0] seq [4];
        int cnt;
        int n;
        seq[0] = 3'b001; seq[1] = 3'b010; seq[2] = 3'b100; seq[3] = 3'b001;

        do_reset();
        check_eq("rst_grant", grant, 0);

        // Back-to-back single-beat grants rotate with no bubble.
        req_valid = 3'b111; req_beats = '0; beat_fire = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check_eq("rr_seq", grant, seq[i]);
        end

        // Four-beat grant with gapped beat_fire.
        do_reset();
        req_valid = 3'b010; req_beats = 12'h030; beat_fire = 1'b0;
        cycle();
        for (int p = 0; p < 4; p++) begin
            cycle();
            cycle();
            check_eq("gap_last", last_beat, p == 3);
            beat_fire = 1'b1;
            if (p == 3) req_valid = 3'b000;
            cycle();
            beat_fire = 1'b0;
        end
        check_eq("gap_end", grant, 0);

        // Asynchronous reset mid-grant.
        do_reset();
        req_valid = 3'b100; req_beats = 12'h200;
        cycle();
        cycle();
        #3 reset = 1'b1;
        #1;
        model_reset();
        check_eq("async_grant", grant, 0);
        check_eq("async_busy", busy, 0);
        @(posedge clock);
        #1;
        reset = 1'b0; req_valid = 3'b111; req_beats = '0;
        cycle();
        check_eq("after_rst_winner", grant, 3'b001);

        // beat_fire while idle sets a sticky error.
        do_reset();
        beat_fire = 1'b1;
        cycle();
        beat_fire = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        check_eq("perr_sticky", proto_err, 1);
        check_eq("perr_grant", grant, 0);

        // Maximum beat count gives 16 beats.
        do_reset();
        req_valid = 3'b001; req_beats = 12'h00F; beat_fire = 1'b1;
        cycle();
        req_valid = 3'b000;
        cnt = (grant == 3'b001) ? 1 : 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (grant[0]) cnt++;
        end
        check_eq("max_beats", cnt, 16);

        // Stalled grant: watchdog release or indefinite hold.
        do_reset();
        req_valid = 3'b010; req_beats = '0; beat_fire = 1'b0;
        cycle();
        req_valid = 3'b110;
        if (WD) begin
            n = 0;
            for (int i = 1; i <= 100 && n == 0; i++) begin
                cycle();
                if (timeout_pulse) n = i;
            end
            check_eq("wd_cycles", n, HM);
            check_eq("wd_newgrant", grant, 3'b100);
            cycle();
            check_eq("wd_pulse_len", timeout_pulse, 0);
        end else begin
            for (int i = 0; i < 200; i++) cycle();
            check_eq("hold_grant", grant, 3'b010);
            check_eq("hold_timeout", timeout_pulse, 0);
        end

        // Random traffic.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            req_valid = N'($urandom_range(0, 7));
            for (int r = 0; r < N; r++) req_beats[r*BW +: BW] = BW'($urandom_range(0, 3));
            beat_fire = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/onehot_grant_sequencer.md
Name: onehot_grant_sequencer

Overview:
- Generates mutually exclusive grants for N_REQ requesters sharing one beat-based channel.
- Acts as the driving end of the exclusivity contract that the channel assertion monitors check: at most one grant is ever high, and grant is low in reset.
- Round-robin arbitration; each grant is held for a requester-specified beat count.
- Sits between requester-side muxing and the shared downstream port.

Parameters:
- N_REQ, 3, number of requesters (2..8)
- BEAT_W, 4, width of per-request beat count (encoded beats-1)
- HOLD_MAX, 64, watchdog limit in cycles (used only with the optional feature)

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  N_REQ  per-requester request; must stay high until its grant ends
- req_beats  in  N_REQ*BEAT_W  per-requester beats-1, slice i = [i*BEAT_W +: BEAT_W]; sampled at grant start
- beat_fire  in  1  downstream accepted one beat this cycle
- grant  out  N_REQ  one-hot or zero grant vector
- grant_id  out  $clog2(N_REQ)  index of the current winner; 0 when idle
- busy  out  1  a grant is active
- last_beat  out  1  the current beat is the final beat of the grant (combinational from state)
- proto_err  out  1  sticky flag; set when beat_fire arrives while idle
- timeout_pulse  out  1  one-cycle pulse on forced release; tied 0 without the feature

Behaviour:
- Reset values: grant=0, grant_id=0, busy=0, last_beat=0, proto_err=0, timeout_pulse=0.
  - Internal: state=IDLE, beats_left=0, rr_ptr=N_REQ-1, so requester 0 has first priority.
- Reset asserted mid-grant clears everything asynchronously; grant drops in the same instant, not at the next edge.
- States: IDLE, GRANT.
- IDLE:
  - If any req_valid is high, pick the first valid index searching from rr_ptr+1 with wrap-around.
  - At the next edge: grant[winner]=1, grant_id=winner, beats_left=req_beats[winner], state=GRANT.
  - Latency from req_valid to grant is 1 cycle.
- GRANT:
  - beat_fire with beats_left>0: beats_left decrements by 1.
  - beat_fire with beats_left==0: the grant ends and rr_ptr=winner.
    - If any req_valid is high (the current winner included), re-arbitrate in the same cycle from the updated rr_ptr. The grant switches directly to the new winner at the next edge, with no bubble and never two bits high.
    - Otherwise go to IDLE with grant=0.
- last_beat = busy & (beats_left==0).
- req_beats=0 means a single-beat grant.
- req_beats all-ones means 2^BEAT_W beats; no overflow occurs because the count is decrement-only.
- req_valid dropping during GRANT is a requester protocol violation. The grant is still held until completion; no flag is raised.
- beat_fire in IDLE has no effect on the datapath and sets proto_err, which stays set until reset.
- Invariant: $countones(grant)<=1 every cycle; grant==0 whenever reset is high.

Optional Feature:
- Macro: ONEHOT_GRANT_SEQ_WATCHDOG_EN.
- With the macro:
  - An 8-bit-or-wider hold counter clears at each grant start and increments every GRANT cycle without beat_fire.
  - On reaching HOLD_MAX, force release as if the last beat fired: same re-arbitration and rr_ptr update, timeout_pulse=1 for that cycle.
  - Any beat_fire resets the counter.
- Without the macro: no counter logic; timeout_pulse is tied 0 and grants are held indefinitely.

Decomposition:
- Shared package onehot_grant_pkg holds:
  - the state enum typedef {IDLE, GRANT};
  - a function that returns the rotating-priority winner index;
  - localparam ID_W=$clog2(N_REQ).
- One sub-module: rr_pick, a combinational rotate-and-priority-encode. Inputs are valid vector and rr_ptr; outputs are found and index. It is reused for both the IDLE and back-to-back arbitration paths.

Test Plan:
- Reset, then req_valid=3'b111 with all req_beats=0 and beat_fire held high: grant sequence 001,010,100,001 on consecutive cycles after a 1-cycle latency, never two bits high.
- req_valid=3'b010, req_beats[1]=3, beat_fire pulsed 4 times with gaps: grant=010 held until the 4th fire, last_beat high only before the 4th fire, then grant=0.
- Requester 2 active with beats=2, reset pulsed asynchronously mid-grant: grant=0 immediately; after reset with all requesters valid, requester 0 wins first.
- beat_fire=1 while IDLE: proto_err=1 and remains 1; grant stays 0.
- req_beats[0]=4'hF with continuous beat_fire: exactly 16 beats granted, then release.
- With the watchdog macro and HOLD_MAX=64: grant to requester 1, no beat_fire for 64 cycles -> timeout_pulse for one cycle, grant moves to waiting requester 2. Without the macro: grant is held for 200 cycles and timeout_pulse stays 0.
